// File: rtl/eedc_decoder.sv
// Hamming(11,7) decoder: syndrome stage then correction stage, valid/ready.
// Define EEDC_ERR_CNT_EN to add saturating corrected/uncorrectable counters.
`timescale 1ns/1ps
module eedc_decoder
`ifdef EEDC_ERR_CNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] codeword_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  data_out,
    output logic        err_corr,
    output logic        err_uncorr,
    output logic [3:0]  syndrome_out
`ifdef EEDC_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
`endif
);

    logic        s1_valid;
    logic [10:0] s1_cw;
    logic [3:0]  s1_syn;
    logic [3:0]  syn_in;
    logic [10:0] fixed;
    logic [6:0]  data_fix;
    logic        s2_adv;
    logic        in_xfer;
    logic        is_corr;
    logic        is_uncorr;

    // Each mask selects the positions whose index has syndrome bit j set.
    assign syn_in = {^(codeword_in & 11'h780),
                     ^(codeword_in & 11'h078),
                     ^(codeword_in & 11'h666),
                     ^(codeword_in & 11'h555)};

    assign s2_adv    = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign in_xfer   = in_valid && in_ready;
    assign is_uncorr = (s1_syn >= 4'd12);
    assign is_corr   = (s1_syn != 4'd0) && !is_uncorr;

    always_comb begin
        fixed = s1_cw;
        for (int k = 0; k < 11; k++) begin
            if (s1_syn == 4'(k + 1)) begin
                fixed[k] = ~s1_cw[k];
            end
        end
        data_fix = {fixed[10:8], fixed[6:4], fixed[2]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_cw        <= '0;
            s1_syn       <= '0;
            out_valid    <= 1'b0;
            data_out     <= '0;
            err_corr     <= 1'b0;
            err_uncorr   <= 1'b0;
            syndrome_out <= '0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    data_out     <= data_fix;
                    err_corr     <= is_corr;
                    err_uncorr   <= is_uncorr;
                    syndrome_out <= s1_syn;
                end
            end
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_cw    <= codeword_in;
                s1_syn   <= syn_in;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

`ifdef EEDC_ERR_CNT_EN
    logic out_xfer;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_xfer) begin
            if (err_corr && (corr_cnt != {CNT_W{1'b1}})) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
            if (err_uncorr && (uncorr_cnt != {CNT_W{1'b1}})) begin
                uncorr_cnt <= uncorr_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eedc_decoder.sv
// Scoreboard bench for eedc_decoder: directed codewords, stream with stall,
// reset with words in flight; counter checks when EEDC_ERR_CNT_EN is defined.
`timescale 1ns/1ps
module tb_eedc_decoder;

    typedef struct packed {
        logic [6:0] data;
        logic [3:0] syn;
        logic       corr;
        logic       uncorr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] codeword_in;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  data_out;
    logic        err_corr;
    logic        err_uncorr;
    logic [3:0]  syndrome_out;

    int tests = 0;
    int fails = 0;
    exp_t q[$];

    always #5 clk = ~clk;

`ifdef EEDC_ERR_CNT_EN
    logic [1:0] corr_cnt;
    logic [1:0] uncorr_cnt;

    eedc_decoder #(.CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .codeword_in(codeword_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .err_corr(err_corr),
        .err_uncorr(err_uncorr), .syndrome_out(syndrome_out),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );
`else
    eedc_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .codeword_in(codeword_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .err_corr(err_corr),
        .err_uncorr(err_uncorr), .syndrome_out(syndrome_out)
    );
`endif

    function automatic logic [10:0] enc(input logic [6:0] d);
        logic [10:0] cw;
        cw = '0;
        cw[2]    = d[0];
        cw[6:4]  = d[3:1];
        cw[10:8] = d[6:4];
        cw[0] = cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10];
        cw[1] = cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10];
        cw[3] = cw[4] ^ cw[5] ^ cw[6];
        cw[7] = cw[8] ^ cw[9] ^ cw[10];
        return cw;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [10:0] cw, input logic [6:0] d,
                        input logic [3:0] s, input logic c,
                        input logic u);
        exp_t e;
        bit   got;
        e = '{data: d, syn: s, corr: c, uncorr: u};
        got = 0;
        in_valid = 1'b1;
        codeword_in = cw;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                got = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: cw %0h never accepted", cw);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() != 0 || out_valid) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d words pending", q.size());
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out: data %0h syn %0h",
                         data_out, syndrome_out);
            end else begin
                e = q.pop_front();
                if (data_out !== e.data || syndrome_out !== e.syn ||
                    err_corr !== e.corr || err_uncorr !== e.uncorr ||
                    (err_corr && err_uncorr)) begin
                    fails++;
                    $display("FAIL out_word: got d=%0h s=%0h c=%0b u=%0b expected d=%0h s=%0h c=%0b u=%0b",
                             data_out, syndrome_out, err_corr, err_uncorr,
                             e.data, e.syn, e.corr, e.uncorr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        codeword_in = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_flags", 32'({err_corr, err_uncorr, syndrome_out}), 32'd0);
`ifdef EEDC_ERR_CNT_EN
        chk("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
`endif
        @(posedge clk);
        #1;

        send(11'h007, 7'h01, 4'd0, 1'b0, 1'b0);
        drain();
        send(11'h017, 7'h01, 4'd5, 1'b1, 1'b0);
        drain();
`ifdef EEDC_ERR_CNT_EN
        chk("corr_cnt_1", 32'(corr_cnt), 32'd1);
`endif
        send(11'h08F, 7'h01, 4'd12, 1'b0, 1'b1);
        send(11'h40F, 7'h41, 4'd15, 1'b0, 1'b1);
        drain();
`ifdef EEDC_ERR_CNT_EN
        chk("uncorr_cnt_2", 32'(uncorr_cnt), 32'd2);
`endif

        fork
            begin
                for (int d = 0; d < 128; d++) begin
                    send(enc(7'(d)), 7'(d), 4'd0, 1'b0, 1'b0);
                end
            end
            begin
                repeat (20) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(11'h006, 7'h01, 4'd1, 1'b1, 1'b0);
        send(11'h003, 7'h01, 4'd3, 1'b1, 1'b0);
        send(11'h047, 7'h01, 4'd7, 1'b1, 1'b0);
        send(11'h407, 7'h01, 4'd11, 1'b1, 1'b0);
        send(11'h017, 7'h01, 4'd5, 1'b1, 1'b0);
        drain();
`ifdef EEDC_ERR_CNT_EN
        chk("corr_cnt_sat", 32'(corr_cnt), 32'd3);
`endif

        out_ready = 1'b0;
        send(11'h017, 7'h01, 4'd5, 1'b1, 1'b0);
        send(11'h003, 7'h01, 4'd3, 1'b1, 1'b0);
        rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flight_rst_out_valid", 32'(out_valid), 32'd0);
        chk("flight_rst_in_ready", 32'(in_ready), 32'd1);
        chk("flight_rst_data", 32'({data_out, syndrome_out}), 32'd0);
`ifdef EEDC_ERR_CNT_EN
        chk("flight_rst_corr_cnt", 32'(corr_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        send(enc(7'h5A), 7'h5A, 4'd0, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
